// File: rtl/dht11_sensor_responder.sv
// dht11_sensor_responder: bus-programmable DHT11 sensor emulator.
// Watches the open-drain line for a host start pulse, then answers with the
// 80/80 us response and a 40-bit humidity/temperature/checksum frame.
module dht11_sensor_responder #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    inout  wire         dht_signal
);

    localparam int TICK_DIV = CLK_HZ / 1_000_000;
    localparam int PS_W     = $clog2(TICK_DIV);
    localparam int US_MAX_A = (START_MIN_US > 80) ? START_MIN_US : 80;
    localparam int US_MAX   = (RESP_WAIT_US > US_MAX_A) ? RESP_WAIT_US : US_MAX_A;
    localparam int US_W     = $clog2(US_MAX + 1);

    // Last microsecond index of each timed phase (phase ends on the tick after it).
    localparam logic [US_W-1:0] START_MIN = US_W'(START_MIN_US);
    localparam logic [US_W-1:0] WAIT_END  = US_W'(RESP_WAIT_US - 1);
    localparam logic [US_W-1:0] END_80    = US_W'(79);
    localparam logic [US_W-1:0] END_50    = US_W'(49);
    localparam logic [US_W-1:0] END_26    = US_W'(25);
    localparam logic [US_W-1:0] END_70    = US_W'(69);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_LOW = 3'd1,
        RESP_WAIT = 3'd2,
        RESP_LOW  = 3'd3,
        RESP_HIGH = 3'd4,
        BIT_LOW   = 3'd5,
        BIT_HIGH  = 3'd6,
        END_LOW   = 3'd7
    } state_t;

    // Frame checksum: byte-wise sum modulo 256.
    function automatic logic [7:0] dht_csum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        dht_csum = a + b + c + d;
    endfunction

    state_t            state_q;
    logic              drive_q;
    logic [PS_W-1:0]   ps_q;
    logic [US_W-1:0]   us_q;
    logic [5:0]        bit_idx_q;
    logic [39:0]       shadow_q;
    logic [7:0]        frames_q;
    logic [7:0]        shorts_q;
    logic [7:0]        hum_h_q;
    logic [7:0]        hum_l_q;
    logic [7:0]        tem_h_q;
    logic [7:0]        tem_l_q;
    logic              en_q;
    logic              badsum_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;

    logic              tick_s;
    logic              fall_s;
    logic              us_sat_s;
    logic              busy_s;
    logic [7:0]        csum_s;
    logic [US_W-1:0]   hi_end_s;
    logic              unused_s;

    assign dht_signal = drive_q ? 1'b0 : 1'bz;

    assign tick_s   = (ps_q == PS_W'(TICK_DIV - 1));
    assign fall_s   = prev_q & ~sync2_q;
    assign us_sat_s = (state_q == START_LOW) && (us_q >= START_MIN);
    assign busy_s   = (state_q != IDLE);
    assign csum_s   = dht_csum(hum_h_q, hum_l_q, tem_h_q, tem_l_q);
    assign hi_end_s = shadow_q[bit_idx_q] ? END_70 : END_26;
    assign unused_s = ^{addr[31:5], addr[1:0], wdata[31:8]};

    // Two-flop synchronizer on the line plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= dht_signal;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // CPU-writable frame bytes and control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hum_h_q  <= 8'h37;
            hum_l_q  <= 8'h00;
            tem_h_q  <= 8'h19;
            tem_l_q  <= 8'h00;
            en_q     <= 1'b1;
            badsum_q <= 1'b0;
        end else if (cs && wr) begin
            case (addr[4:2])
                3'd0: hum_h_q <= wdata[7:0];
                3'd1: hum_l_q <= wdata[7:0];
                3'd2: tem_h_q <= wdata[7:0];
                3'd3: tem_l_q <= wdata[7:0];
                3'd5: begin
                    en_q     <= wdata[0];
                    badsum_q <= wdata[1];
                end
                default: ;
            endcase
        end
    end

    // Protocol FSM with us prescaler, phase timer, line driver and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drive_q   <= 1'b0;
            ps_q      <= {PS_W{1'b0}};
            us_q      <= {US_W{1'b0}};
            bit_idx_q <= 6'd0;
            shadow_q  <= 40'd0;
            frames_q  <= 8'd0;
            shorts_q  <= 8'd0;
        end else begin
            // Timebase runs only while a phase is being timed.
            if (state_q == IDLE) begin
                ps_q <= {PS_W{1'b0}};
                us_q <= {US_W{1'b0}};
            end else begin
                ps_q <= tick_s ? {PS_W{1'b0}} : ps_q + 1'b1;
                if (tick_s && !us_sat_s) begin
                    us_q <= us_q + 1'b1;
                end
            end

            // Every transition below also restarts the timebase.
            case (state_q)
                IDLE: begin
                    drive_q <= 1'b0;
                    if (en_q && fall_s) begin
                        state_q <= START_LOW;
                        ps_q    <= {PS_W{1'b0}};
                        us_q    <= {US_W{1'b0}};
                    end
                end
                START_LOW: begin
                    if (sync2_q) begin
                        ps_q <= {PS_W{1'b0}};
                        us_q <= {US_W{1'b0}};
                        if (us_q >= START_MIN) begin
                            state_q  <= RESP_WAIT;
                            shadow_q <= {hum_h_q, hum_l_q, tem_h_q, tem_l_q,
                                         csum_s ^ {7'd0, badsum_q}};
                        end else begin
                            state_q <= IDLE;
                            if (shorts_q != 8'hFF) begin
                                shorts_q <= shorts_q + 8'd1;
                            end
                        end
                    end
                end
                RESP_WAIT: begin
                    if (tick_s && us_q == WAIT_END) begin
                        state_q <= RESP_LOW;
                        drive_q <= 1'b1;
                        ps_q    <= {PS_W{1'b0}};
                        us_q    <= {US_W{1'b0}};
                    end
                end
                RESP_LOW: begin
                    if (tick_s && us_q == END_80) begin
                        state_q <= RESP_HIGH;
                        drive_q <= 1'b0;
                        ps_q    <= {PS_W{1'b0}};
                        us_q    <= {US_W{1'b0}};
                    end
                end
                RESP_HIGH: begin
                    if (tick_s && us_q == END_80) begin
                        state_q   <= BIT_LOW;
                        drive_q   <= 1'b1;
                        bit_idx_q <= 6'd39;
                        ps_q      <= {PS_W{1'b0}};
                        us_q      <= {US_W{1'b0}};
                    end
                end
                BIT_LOW: begin
                    if (tick_s && us_q == END_50) begin
                        state_q <= BIT_HIGH;
                        drive_q <= 1'b0;
                        ps_q    <= {PS_W{1'b0}};
                        us_q    <= {US_W{1'b0}};
                    end
                end
                BIT_HIGH: begin
                    if (tick_s && us_q == hi_end_s) begin
                        drive_q <= 1'b1;
                        ps_q    <= {PS_W{1'b0}};
                        us_q    <= {US_W{1'b0}};
                        if (bit_idx_q != 6'd0) begin
                            bit_idx_q <= bit_idx_q - 6'd1;
                            state_q   <= BIT_LOW;
                        end else begin
                            state_q <= END_LOW;
                        end
                    end
                end
                END_LOW: begin
                    if (tick_s && us_q == END_50) begin
                        state_q  <= IDLE;
                        drive_q  <= 1'b0;
                        frames_q <= frames_q + 8'd1;
                        ps_q     <= {PS_W{1'b0}};
                        us_q     <= {US_W{1'b0}};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read mux.
    always_comb begin
        rdata = 32'd0;
        case (addr[4:2])
            3'd0:    rdata = {24'd0, hum_h_q};
            3'd1:    rdata = {24'd0, hum_l_q};
            3'd2:    rdata = {24'd0, tem_h_q};
            3'd3:    rdata = {24'd0, tem_l_q};
            3'd4:    rdata = {24'd0, csum_s};
            3'd5:    rdata = {8'd0, shorts_q, frames_q, 5'd0, busy_s, badsum_q, en_q};
            default: rdata = 32'd0;
        endcase
    end

endmodule
